// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-format defaults and the receiver state encoding.
package uart_pkg;

    localparam int unsigned DATA_BITS_DEF  = 8;
    localparam int unsigned OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, synchronous active-low reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualify, LSB-first data, optional parity,
// stop-bit check, and break handling (waits for the line to return high).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 CLK100MHZ,
    input  logic                 resetn,
    input  logic                 rx_tick,
    input  logic                 rx,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
    localparam int unsigned MID   = OVERSAMPLE / 2 - 1;
    localparam int unsigned LAST  = OVERSAMPLE - 1;

    logic rx_s;

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 par_acc_q, par_acc_d;
    logic [DATA_BITS-1:0] data_out_d;
    logic                 data_valid_d, parity_err_d, framing_err_d, busy_d;
    logic                 tick_last;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk    (CLK100MHZ),
        .resetn (resetn),
        .d      (rx),
        .q      (rx_s)
    );

    // State and output registers
    always_ff @(posedge CLK100MHZ) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            par_acc_q   <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_en_q    <= par_en_d;
            par_odd_q   <= par_odd_d;
            par_acc_q   <= par_acc_d;
            data_out    <= data_out_d;
            data_valid  <= data_valid_d;
            parity_err  <= parity_err_d;
            framing_err <= framing_err_d;
            busy        <= busy_d;
        end
    end

    // Bit-period sample point: last tick of the oversample window
    assign tick_last = rx_tick && (cnt_q == CNT_W'(LAST));

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        par_en_d      = par_en_q;
        par_odd_d     = par_odd_q;
        par_acc_d     = par_acc_q;
        data_out_d    = data_out;
        data_valid_d  = 1'b0;
        parity_err_d  = parity_err;
        framing_err_d = framing_err;

        if (rx_tick && (state_q == DATA || state_q == PARITY || state_q == STOP)) begin
            cnt_d = (cnt_q == CNT_W'(LAST)) ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (rx_tick && !rx_s) begin
                    state_d   = START;
                    cnt_d     = '0;
                    par_en_d  = parity_en;
                    par_odd_d = parity_odd;
                end
            end
            START: begin
                if (rx_tick) begin
                    if (cnt_q == CNT_W'(MID)) begin
                        // A high line at mid start bit is a glitch, not a frame
                        if (!rx_s) begin
                            state_d   = DATA;
                            cnt_d     = '0;
                            bit_d     = '0;
                            par_acc_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick_last) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    par_acc_d = par_acc_q ^ rx_s;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (tick_last) begin
                    par_acc_d = par_acc_q ^ rx_s ^ par_odd_q;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (tick_last) begin
                    data_valid_d  = 1'b1;
                    data_out_d    = shift_q;
                    parity_err_d  = par_en_q & par_acc_q;
                    framing_err_d = ~rx_s;
                    state_d       = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx_tick && rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference queue plus directed literal checks.
module tb_uart_rx;

    localparam int unsigned TICK_DIV = 4;

    logic       CLK100MHZ  = 1'b0;
    logic       resetn     = 1'b0;
    logic       rx_tick    = 1'b0;
    logic       rx         = 1'b1;
    logic       parity_en  = 1'b0;
    logic       parity_odd = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, parity_err, framing_err, busy;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_valid  = 0;
    logic prev_valid = 1'b0;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .CLK100MHZ   (CLK100MHZ),
        .resetn      (resetn),
        .rx_tick     (rx_tick),
        .rx          (rx),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .parity_err  (parity_err),
        .framing_err (framing_err),
        .busy        (busy)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Every completed frame must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK100MHZ);
            if (resetn) begin
                if (data_valid) begin
                    n_valid++;
                    check("valid_single_cycle", 32'(prev_valid), 32'(1'b0));
                    check("frame_expected", 32'(exp_q.size() != 0), 32'(1'b1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("frame_data", 32'(data_out), 32'(e.d));
                        check("frame_parity_err", 32'(parity_err), 32'(e.pe));
                        check("frame_framing_err", 32'(framing_err), 32'(e.fe));
                        check("frame_busy", 32'(busy), 32'(e.fe));
                    end
                end
                prev_valid = data_valid;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    task automatic do_tick();
        rx_tick = 1'b1;
        @(posedge CLK100MHZ); #1;
        rx_tick = 1'b0;
        repeat (TICK_DIV - 1) @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic send_bit(input logic v, input int n);
        rx = v;
        repeat (n) do_tick();
    endtask

    // One frame; parity bit is the correct one unless pflip, and the config may be scrambled mid-frame
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                              input logic pflip, input logic stop_v, input int brk,
                              input logic scramble);
        exp_t e;
        logic pbit;
        parity_en  = pen;
        parity_odd = podd;
        e.d  = d;
        e.pe = pen & pflip;
        e.fe = ~stop_v;
        exp_q.push_back(e);
        send_bit(1'b0, 4);
        if (scramble) begin
            parity_en  = 1'($urandom);
            parity_odd = 1'($urandom);
        end
        send_bit(1'b0, 12);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
        if (pen) begin
            pbit = (^d) ^ podd;
            send_bit(pbit ^ pflip, 16);
        end
        send_bit(stop_v, 16);
        if (!stop_v) begin
            send_bit(1'b0, brk);
            rx = 1'b1;
        end
    endtask

    initial begin
        int v0;
        logic sv;
        int ok;

        repeat (3) @(posedge CLK100MHZ);
        #1;
        check("rst_data_out", 32'(data_out), 32'(8'h00));
        check("rst_data_valid", 32'(data_valid), 32'(1'b0));
        check("rst_parity_err", 32'(parity_err), 32'(1'b0));
        check("rst_framing_err", 32'(framing_err), 32'(1'b0));
        check("rst_busy", 32'(busy), 32'(1'b0));
        resetn = 1'b1;
        send_bit(1'b1, 20);

        v0 = n_valid;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send_bit(1'b1, 4);
        check("f55_data", 32'(data_out), 32'(8'h55));
        check("f55_pulses", 32'(n_valid - v0), 32'd1);
        check("f55_perr", 32'(parity_err), 32'(1'b0));
        check("f55_ferr", 32'(framing_err), 32'(1'b0));

        send_frame(8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send_bit(1'b1, 4);
        check("fa3_good_perr", 32'(parity_err), 32'(1'b0));
        send_frame(8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        send_bit(1'b1, 4);
        check("fa3_bad_perr", 32'(parity_err), 32'(1'b1));
        check("fa3_bad_data", 32'(data_out), 32'(8'hA3));

        v0 = n_valid;
        send_bit(1'b0, 4);
        check("glitch_busy", 32'(busy), 32'(1'b1));
        send_bit(1'b1, 20);
        check("glitch_no_valid", 32'(n_valid - v0), 32'd0);
        check("glitch_idle", 32'(busy), 32'(1'b0));
        check("glitch_data_held", 32'(data_out), 32'(8'hA3));

        v0 = n_valid;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        rx = 1'b0;
        send_bit(1'b0, 40);
        check("brk_ferr", 32'(framing_err), 32'(1'b1));
        check("brk_data", 32'(data_out), 32'(8'h3C));
        check("brk_busy", 32'(busy), 32'(1'b1));
        check("brk_one_frame", 32'(n_valid - v0), 32'd1);
        send_bit(1'b1, 20);
        check("brk_released", 32'(busy), 32'(1'b0));

        v0 = n_valid;
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(i[0], 16);
        send_bit(1'b1, 8);
        resetn = 1'b0;
        rx     = 1'b1;
        @(posedge CLK100MHZ); #1;
        check("mid_rst_data", 32'(data_out), 32'(8'h00));
        check("mid_rst_ferr", 32'(framing_err), 32'(1'b0));
        check("mid_rst_busy", 32'(busy), 32'(1'b0));
        @(posedge CLK100MHZ); #1;
        resetn = 1'b1;
        send_bit(1'b1, 20);
        check("mid_rst_no_valid", 32'(n_valid - v0), 32'd0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send_bit(1'b1, 4);
        check("f81_data", 32'(data_out), 32'(8'h81));

        v0 = n_valid;
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send_bit(1'b1, 4);
        check("b2b_pulses", 32'(n_valid - v0), 32'd2);
        check("b2b_last", 32'(data_out), 32'(8'hFF));

        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                send_bit(1'b0, $urandom_range(1, 6));
                send_bit(1'b1, 20);
            end
            sv = ($urandom_range(0, 5) != 0);
            send_frame(8'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                       sv, $urandom_range(0, 40), 1'b1);
            if (sv) send_bit(1'b1, $urandom_range(0, 20));
            else    send_bit(1'b1, $urandom_range(2, 20));
        end

        ok = 0;
        for (int c = 0; c < 2000; c++) begin
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
            @(posedge CLK100MHZ);
        end
        check("drain_all_frames", 32'(ok), 32'd1);
        check("drain_idle", 32'(busy), 32'(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, rx_tick pulses per bit period.
REQ-003 SHALL use one clock, CLK100MHZ; reset is synchronous and active-low; port name resetn.
REQ-004 CLK100MHZ  input  1  system clock; all state changes on its rising edge.
REQ-005 resetn  input  1  synchronous active-low reset.
REQ-006 rx_tick  input  1  single-cycle enable at 16x baud, from the baud-rate generator's receive rate.
REQ-007 rx  input  1  asynchronous serial line; idle high.
REQ-008 parity_en  input  1  1 = one parity bit follows the data bits.
REQ-009 parity_odd  input  1  1 = odd parity, 0 = even; ignored when parity_en = 0.
REQ-010 data_out  output  DATA_BITS  last received byte; held until the next frame completes.
REQ-011 data_valid  output  1  one-cycle pulse when a frame completes.
REQ-012 parity_err  output  1  parity result for the frame; valid with data_valid.
REQ-013 framing_err  output  1  stop bit sampled 0; valid with data_valid.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-016 States SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-017 The tick counter (4 bits) SHALL advance only on cycles with rx_tick = 1.
REQ-018 IDLE: on rx_tick with rx_s = 0 -> START, tick counter = 0, parity_en/parity_odd latched.
REQ-019 START: at tick count 7 (mid-bit): if rx_s = 0 -> DATA, counter = 0; if rx_s = 1 -> IDLE (glitch), no outputs change.
REQ-020 DATA: sample rx_s at count 15, LSB first into the shift register; after DATA_BITS samples -> PARITY if latched parity_en, else STOP.
REQ-021 PARITY: sample at count 15; parity_err = XOR(data bits, parity bit) XOR latched parity_odd.
REQ-022 STOP: sample at count 15. If rx_s = 1 -> IDLE. If rx_s = 0 -> framing_err = 1, -> WAIT_HIGH.
REQ-023 On the cycle after the stop sample, data_valid SHALL be 1 for exactly one CLK100MHZ cycle; data_out, parity_err and framing_err SHALL update on that same cycle.
REQ-024 parity_err SHALL be 0 for frames without parity.
REQ-025 A frame with errors SHALL still update data_out.
REQ-026 WAIT_HIGH: -> IDLE on the first rx_tick with rx_s = 1. Break conditions SHALL produce no further frames.
REQ-027 A start bit immediately following a valid stop bit SHALL be detected (back-to-back frames).
REQ-028 parity_en/parity_odd changes mid-frame SHALL NOT affect the current frame.

Reset
REQ-029 With resetn = 0 at a clock edge: state = IDLE; counters = 0; data_out = 0; data_valid = 0; parity_err = 0; framing_err = 0; busy = 0; synchronizer flops = 1.
REQ-030 Reset mid-frame SHALL abort the frame with no data_valid pulse.

Structure
REQ-031 A shared package uart_pkg SHALL hold the state enum type and the OVERSAMPLE/DATA_BITS defaults, for reuse by the future uart_tx.
REQ-032 The synchronizer SHALL be a separate sub-module, sync_2ff.

Verification
REQ-033 0x55, no parity, 16-tick bits -> data_out = 0x55; one data_valid pulse; both error flags = 0.
REQ-034 0xA3, even parity, parity bit 0 -> parity_err = 0; same frame with parity bit 1 -> parity_err = 1, data_out = 0xA3.
REQ-035 rx low for 4 ticks, then high -> returns to IDLE; no data_valid; busy back to 0.
REQ-036 0x3C with stop bit = 0, line held low 40 ticks -> framing_err = 1, data_out = 0x3C; no new frame until rx is high.
REQ-037 resetn pulsed low during DATA bit 4 -> no data_valid; all outputs at reset values; next clean frame 0x81 received correctly.
REQ-038 Back-to-back frames 0x00 then 0xFF, no idle gap -> two data_valid pulses, values in order.
